uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter datapath among NREQ byte producers.
- Sits between the producers and the transmitter controller.
- Picks one requester, latches its byte, issues a single-cycle tx_start, then holds ownership until the transmitter reports completion.
- Gates new grants on the global enable and on the CTS flow-control input.

Parameters:
- NREQ, 4: number of requesters; legal range 2..8.
- TIMEOUT, 65535: watchdog limit in clk cycles. Used only when UART_ARB_TIMEOUT_EN is defined.
- IDW, $clog2(NREQ): width of the owner index. Derived; do not override.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  global enable; low blocks new grants.
- cts  input  1  clear-to-send from the link partner; low blocks new grants.
- req  input  NREQ  per-requester level request.
- wdata  input  NREQ*8  byte for requester i on bits [8i+7:8i].
- gnt  output  NREQ  one-hot, one-cycle pulse; marks the cycle wdata[i] is captured.
- owner  output  IDW  index of the current or last granted requester.
- tx_start  output  1  one-cycle start pulse to the transmitter.
- tx_data  output  8  latched byte, stable from START until the next grant.
- tx_busy  input  1  transmitter busy level.
- tx_done  input  1  transmitter completion pulse (one clk cycle).
- err  output  1  one-cycle timeout pulse.

Behaviour:
Reset (rst low, asynchronous):
- state=IDLE, gnt=0, tx_start=0, tx_data=0, owner=0, err=0.
- Round-robin pointer ptr=0, so requester 0 has highest priority first.
- Timeout counter=0.
- Release is synchronous to clk.

State machine; all outputs registered:
- IDLE:
  - If en && cts && |req, select the winner: the first set req bit searching ptr, ptr+1, … wrapping mod NREQ.
  - On the next edge: tx_data<=wdata[winner], owner<=winner, go to START.
  - Otherwise stay in IDLE.
- START (exactly 1 cycle):
  - gnt[owner]=1 and tx_start=1.
  - Next state is WAIT_BUSY.
- WAIT_BUSY:
  - On tx_busy=1, go to WAIT_DONE.
  - On tx_done=1 (fast transmitter, busy never observed), treat as WAIT_DONE completion.
- WAIT_DONE:
  - On tx_done=1: ptr<=(owner+1) mod NREQ, go to IDLE.

Latency:
- req sampled high in IDLE at cycle n gives gnt and tx_start in cycle n+1.
- After tx_done in cycle m, IDLE is entered in m+1; the next earliest grant is at m+2.

Boundary rules:
- Simultaneous requests: exactly one gnt bit ever set. Pointer rotation guarantees no requester waits more than NREQ-1 transfers.
- ptr wrap: owner=NREQ-1 gives ptr=0.
- req dropped after gnt: no effect; the byte is already latched.
- req dropped while in IDLE before selection: not granted.
- en or cts falling during START/WAIT_*: the current byte completes; only new grants are blocked.
- tx_done arriving in IDLE or START: ignored.
- tx_start is never reasserted until tx_done has been consumed (or the timeout fires).
- Reset mid-transfer: immediate return to reset values; tx_start is never glitched high.
- Non-power-of-two NREQ: the mod arithmetic is explicit; ptr never holds a value ≥NREQ.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entry to WAIT_BUSY and increments each cycle in WAIT_BUSY/WAIT_DONE.
  - When it reaches TIMEOUT without tx_done: err=1 for one cycle, ptr<=(owner+1) mod NREQ, state<=IDLE.
  - tx_done in the same cycle as the timeout wins, so err is not raised.
- Undefined:
  - No counter is instantiated; the FSM waits indefinitely.
  - err is tied to 0.

Test Plan:
1. Reset, then req=4'b0100, wdata[2]=8'hA5, cts=en=1. Expect gnt=4'b0100 and tx_start one cycle later, tx_data=8'hA5, owner=2. Then tx_busy high 10 cycles and tx_done pulse: IDLE, ptr=3.
2. req=4'b1111 held, transmitter model finishing each byte. Expect grant order 0,1,2,3,0, gnt always one-hot, one grant per tx_done.
3. cts=0 with req=4'b0001 for 20 cycles: no gnt or tx_start. Raise cts: gnt=4'b0001 within 2 cycles. Drop cts mid-transfer: byte still completes via tx_done.
4. Assert rst low during WAIT_DONE, then release. Expect all outputs 0 immediately, ptr=0, and a fresh grant to the lowest pending requester.
5. UART_ARB_TIMEOUT_EN defined, TIMEOUT=50, tx_busy=1 held with no tx_done. Expect err pulse exactly 50 cycles after WAIT_BUSY entry, return to IDLE, ptr advanced. Without the macro: no err, FSM stays in WAIT_DONE.
6. Fast transmitter: tx_done one cycle after tx_start with tx_busy never high. Expect a clean return to IDLE and no duplicate tx_start.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers.
// Optional watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter  int NREQ    = 4,
   parameter  int TIMEOUT = 65535,
   localparam int IDW     = $clog2(NREQ)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_cts,
   input  logic [NREQ-1:0]   i_req,
   input  logic [NREQ*8-1:0] i_wdata,
   output logic [NREQ-1:0]   o_gnt,
   output logic [IDW-1:0]    o_owner,
   output logic              o_tx_start,
   output logic [7:0]        o_tx_data,
   input  logic              i_tx_busy,
   input  logic              i_tx_done,
   output logic              o_err
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE} state_t;

   localparam logic [IDW-1:0]  LAST   = IDW'(NREQ - 1);
   localparam logic [IDW:0]    NREQ_W = (IDW + 1)'(NREQ);
   localparam logic [NREQ-1:0] ONE    = NREQ'(1);

   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_chk
      $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT 1..65535");
   end

   state_t            r_state, w_state_nxt;
   logic [IDW-1:0]    r_ptr, r_owner, w_win;
   logic [IDW:0]      w_idx;
   logic [NREQ-1:0]   r_gnt;
   logic [7:0]        r_tx_data;
   logic              r_tx_start;
   logic              w_found, w_load, w_release, w_timeout;

   // First set request starting at ptr; the extra index bit lets the wrap be a plain subtract.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = {1'b0, r_ptr} + (IDW + 1)'(k);
         if (w_idx >= NREQ_W) w_idx = w_idx - NREQ_W;
         if (!w_found && i_req[w_idx[IDW-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_idx[IDW-1:0];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_en && i_cts && w_found) begin
               w_load      = 1'b1;
               w_state_nxt = S_START;
            end
         end
         S_START: w_state_nxt = S_WAIT_BUSY;
         S_WAIT_BUSY, S_WAIT_DONE: begin
            // A done pulse in WAIT_BUSY covers transmitters too fast to show busy.
            if (i_tx_done || w_timeout) begin
               w_release   = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_state == S_WAIT_BUSY && i_tx_busy) begin
               w_state_nxt = S_WAIT_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_gnt      <= '0;
         r_tx_start <= 1'b0;
         r_tx_data  <= '0;
         r_owner    <= '0;
         r_ptr      <= '0;
      end else begin
         r_gnt      <= '0;
         r_tx_start <= w_load;
         if (w_load) begin
            r_gnt     <= ONE << w_win;
            r_tx_data <= i_wdata[{w_win, 3'b000} +: 8];
            r_owner   <= w_win;
         end
         if (w_release) r_ptr <= (r_owner == LAST) ? '0 : r_owner + 1'b1;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_M1 = 16'(TIMEOUT - 1);

   logic [15:0] r_cnt;
   logic        r_err;
   logic        w_waiting;

   assign w_waiting = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
   // Completion in the expiry cycle takes precedence over the error.
   assign w_timeout = w_waiting && (r_cnt == TO_M1) && !i_tx_done;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         r_err <= w_timeout;
         if (r_state == S_START) r_cnt <= '0;
         else if (w_waiting)     r_cnt <= r_cnt + 16'd1;
      end
   end

   assign o_err = r_err;
`else
   assign w_timeout = 1'b0;
   assign o_err     = 1'b0;
`endif

   assign o_gnt      = r_gnt;
   assign o_owner    = r_owner;
   assign o_tx_start = r_tx_start;
   assign o_tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant order, flow control, reset, watchdog, fast transmitter.
module tb_uart_tx_arbiter;
   localparam int NREQ = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              en, cts, tx_busy, tx_done;
   logic [NREQ-1:0]   req;
   logic [NREQ*8-1:0] wdata;
   logic [NREQ-1:0]   gnt;
   logic [1:0]        owner;
   logic              tx_start, err;
   logic [7:0]        tx_data;

   logic [7:0] b [NREQ] = '{8'h40, 8'h71, 8'hA5, 8'hD3};

   int checks   = 0;
   int failures = 0;
   int n;

   uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(50)) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_cts(cts), .i_req(req), .i_wdata(wdata),
      .o_gnt(gnt), .o_owner(owner), .o_tx_start(tx_start), .o_tx_data(tx_data),
      .i_tx_busy(tx_busy), .i_tx_done(tx_done), .o_err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for tx_start and checks the grant contents; n = edges taken.
   task automatic wait_grant(input int idx, input int maxc, output int nt);
      logic found;
      found = 1'b0;
      nt    = 0;
      while (!found && nt < maxc) begin
         tick();
         nt++;
         if (tx_start === 1'b1) found = 1'b1;
      end
      chk($sformatf("grant_seen_%0d", idx), 32'(found), 32'd1);
      chk($sformatf("gnt_%0d", idx), 32'(gnt), 32'd1 << idx);
      chk($sformatf("owner_%0d", idx), 32'(owner), 32'(idx));
      chk($sformatf("tx_data_%0d", idx), 32'(tx_data), 32'(b[idx]));
   endtask

   // From START: busy for busy_cyc cycles, then a done pulse back to IDLE.
   task automatic xfer(input int busy_cyc, input logic [7:0] exp_data);
      tick();
      chk("start_one_cycle", 32'(tx_start), 32'd0);
      chk("gnt_one_cycle", 32'(gnt), 32'd0);
      if (busy_cyc > 0) begin
         tx_busy = 1'b1;
         for (int i = 0; i < busy_cyc; i++) begin
            tick();
            chk("no_restart_busy", 32'(tx_start), 32'd0);
         end
         tx_busy = 1'b0;
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("no_restart_done", 32'(tx_start), 32'd0);
      chk("data_stable", 32'(tx_data), 32'(exp_data));
      chk("no_err", 32'(err), 32'd0);
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; cts = 1'b0; req = '0;
      tx_busy = 1'b0; tx_done = 1'b0;
      wdata = {b[3], b[2], b[1], b[0]};
      tick();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_start", 32'(tx_start), 32'd0);
      chk("rst_data", 32'(tx_data), 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      tick();
      rst = 1'b1;

      // Single requester 2, slow transmitter; ptr then points at 3.
      en = 1'b1; cts = 1'b1; req = 4'b0100;
      wait_grant(2, 2, n);
      chk("lat_first", 32'(n), 32'd1);
      req = '0;
      xfer(10, b[2]);
      req = 4'b1001;
      wait_grant(3, 2, n);
      xfer(3, b[3]);

      // All requesting: strict rotation, one grant per done, grant at m+2.
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_grant(k % 4, 2, n);
         chk("lat_rr", 32'(n), 32'd1);
         if (k == 4) req = '0;
         xfer(3, b[k % 4]);
      end

      // CTS blocks new grants only; in-flight byte completes.
      cts = 1'b0; req = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("cts_block", 32'({gnt, tx_start}), 32'd0);
      end
      cts = 1'b1;
      wait_grant(0, 2, n);
      tick();
      cts = 1'b0; tx_busy = 1'b1;
      repeat (4) tick();
      tx_busy = 1'b0; tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("cts_block_after", 32'(tx_start), 32'd0);
      end
      chk("cts_data_kept", 32'(tx_data), 32'(b[0]));

      // Reset during WAIT_DONE; ptr returns to 0 (req 0011 picks 0, stale ptr 1 would pick 1).
      cts = 1'b1; req = 4'b0100;
      wait_grant(2, 2, n);
      req = '0;
      tick();
      tx_busy = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("midrst_gnt", 32'(gnt), 32'd0);
      chk("midrst_start", 32'(tx_start), 32'd0);
      chk("midrst_data", 32'(tx_data), 32'd0);
      chk("midrst_owner", 32'(owner), 32'd0);
      tx_busy = 1'b0; req = 4'b0011;
      tick();
      tick();
      chk("in_rst_start", 32'(tx_start), 32'd0);
      rst = 1'b1;
      wait_grant(0, 2, n);
      chk("lat_after_rst", 32'(n), 32'd1);
      req = '0;
      xfer(2, b[0]);

      // Transmitter stuck busy: watchdog (if built) or indefinite wait.
      req = 4'b0010;
      wait_grant(1, 2, n);
      req = 4'b0110;
      tick();
      tx_busy = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
      for (int t = 1; t <= 50; t++) begin
         tick();
         chk($sformatf("to_err_t%0d", t), 32'(err), (t == 50) ? 32'd1 : 32'd0);
         chk("to_no_start", 32'(tx_start), 32'd0);
      end
      tx_busy = 1'b0;
`else
      for (int t = 1; t <= 60; t++) begin
         tick();
         chk("no_to_err", 32'(err), 32'd0);
         chk("no_to_start", 32'(tx_start), 32'd0);
      end
      tx_busy = 1'b0; tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
`endif
      wait_grant(2, 2, n);
      chk("err_single", 32'(err), 32'd0);
      req = '0;

      // Fast transmitter: done right after start, busy never seen.
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("fast_no_dup", 32'(tx_start), 32'd0);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      repeat (2) tick();
      chk("done_in_idle", 32'(tx_start), 32'd0);

      // Done during START is ignored; FSM keeps waiting for a real done.
      req = 4'b1000;
      wait_grant(3, 2, n);
      req = '0; tx_done = 1'b1;
      tick();
      tx_done = 1'b0; req = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("start_done_ignored", 32'(tx_start), 32'd0);
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0; en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("en_block", 32'(tx_start), 32'd0);
      end
      en = 1'b1;
      wait_grant(0, 2, n);
      chk("lat_en", 32'(n), 32'd1);
      req = '0;
      xfer(0, b[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
